// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared types and constants for the instruction fetch sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Fetch sequencer states: normal fetching, or draining a wrong-path request
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  // One prefetch FIFO entry: the fetched word and the address it came from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam int unsigned WORD_BYTES = 4;

  // Force a byte address onto a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Purpose  : Small synchronous FIFO with flush; head is presented
//             combinationally. DEPTH must be a power of two, 2 or more.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Pop only real data; push only into free space (a same-cycle pop frees one)
  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  // Storage array; contents need no reset because count qualifies them
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_ctrl
//  Purpose  : Fetch sequencer between PC logic and instruction memory. Issues
//             word fetches over req/ack, buffers words in a prefetch FIFO and
//             presents {inst, pc} to IF/ID. Handles stall and redirect.
//  Options  : FETCH_PERF_CNT_EN adds saturating fetch/bubble counters.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        align_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_drain_addr;
  logic          r_active;
  logic          r_align_err;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_wdata;
  logic          w_req;
  logic          w_xfer;
  logic          w_push;
  logic          w_pop;
  logic          w_not_full;

  // r_active keeps mem_req low until the first clock after reset release
  assign w_not_full = (w_count < CNT_W'(FIFO_DEPTH));
  assign w_req      = r_active && ((r_state == DRAIN) || w_not_full);
  assign w_xfer     = w_req && mem_ack;
  assign w_push     = w_xfer && (r_state == FETCH) && !redirect;
  assign inst_valid = (w_count != '0);
  assign w_pop      = inst_valid && !stall && !redirect;
  assign w_wdata    = '{pc: r_fetch_pc, inst: mem_rdata};

  assign mem_req   = w_req;
  assign mem_addr  = (r_state == DRAIN) ? r_drain_addr : r_fetch_pc;
  assign inst      = inst_valid ? w_head.inst : '0;
  assign inst_pc   = inst_valid ? w_head.pc   : '0;
  assign align_err = r_align_err;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect),
    .wdata (w_wdata),
    .count (w_count),
    .head  (w_head)
  );

  // Fetch FSM and PC: redirect overrides advance; an unacked request at
  // redirect time is remembered and drained with its original address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FETCH;
      r_fetch_pc   <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_active     <= 1'b0;
      r_align_err  <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (redirect && (redirect_pc[1:0] != 2'b00)) begin
        r_align_err <= 1'b1;
      end
      case (r_state)
        FETCH: begin
          if (redirect) begin
            r_fetch_pc <= word_align(redirect_pc);
            if (w_req && !mem_ack) begin
              r_state      <= DRAIN;
              r_drain_addr <= r_fetch_pc;
            end
          end else if (w_xfer) begin
            r_fetch_pc <= r_fetch_pc + 32'(WORD_BYTES);
          end
        end
        DRAIN: begin
          if (redirect) begin
            r_fetch_pc <= word_align(redirect_pc);
          end
          if (mem_ack) begin
            r_state <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters: accepted fetches and cycles without a valid head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (w_push && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (!inst_valid && (perf_bubble_cnt != 32'hFFFF_FFFF)) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_ctrl
//  Purpose  : Self-checking bench for inst_fetch_ctrl: directed scenarios plus
//             a randomized run against a program-order reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        align_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Memory model: ack after 'lat' wait cycles; 'noise' toggles ack while idle
  logic [1:0] lat = 2'd0;
  logic       noise = 1'b0;
  int         wait_cnt;

  function automatic logic [31:0] memfun(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  assign mem_ack   = mem_req ? (wait_cnt >= int'(lat)) : noise;
  assign mem_rdata = memfun(mem_addr);

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always #5 clk = ~clk;

  inst_fetch_ctrl #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .align_err   (align_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  // Reset, then leave the bench at the negedge of the first requesting cycle
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; noise = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL reset_release_req: got %b want 1", mem_req); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    vectors++; if (mem_addr !== RESET_PC) begin miscompares++; $display("FAIL reset_mem_addr: got %h want %h", mem_addr, RESET_PC); end
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
    vectors++; if (inst !== 32'h0) begin miscompares++; $display("FAIL reset_inst: got %h want 0", inst); end
    vectors++; if (inst_pc !== 32'h0) begin miscompares++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
    vectors++; if (align_err !== 1'b0) begin miscompares++; $display("FAIL reset_align_err: got %b want 0", align_err); end
`ifdef FETCH_PERF_CNT_EN
    vectors++; if (perf_fetch_cnt !== 32'h0) begin miscompares++; $display("FAIL reset_perf_fetch: got %h want 0", perf_fetch_cnt); end
    vectors++; if (perf_bubble_cnt !== 32'h0) begin miscompares++; $display("FAIL reset_perf_bubble: got %h want 0", perf_bubble_cnt); end
`endif
  endtask

  // Same-cycle ack, no stall: one new address and one instruction per cycle
  task automatic test_stream();
    lat = 2'd0;
    do_reset();
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL stream_addr0: got %h want 0", mem_addr); end
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL stream_valid0: got %b want 0", inst_valid); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      vectors++; if (mem_addr !== 32'(4 * i)) begin miscompares++; $display("FAIL stream_addr: got %h want %h", mem_addr, 32'(4 * i)); end
      vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * (i - 1))) begin miscompares++; $display("FAIL stream_pc: got v=%b pc=%h want v=1 pc=%h", inst_valid, inst_pc, 32'(4 * (i - 1))); end
      vectors++; if (inst !== memfun(32'(4 * (i - 1)))) begin miscompares++; $display("FAIL stream_inst: got %h want %h", inst, memfun(32'(4 * (i - 1)))); end
    end
  endtask

  // Stall fills the two-entry FIFO, then requests stop; release resumes in order
  task automatic test_stall();
    lat = 2'd0;
    do_reset();
    stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL stall_full_req: cyc %0d got %b want 0", i, mem_req); end
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin miscompares++; $display("FAIL stall_hold_pc: cyc %0d got v=%b pc=%h want v=1 pc=0", i, inst_valid, inst_pc); end
      end
    end
    stall = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * j)) begin miscompares++; $display("FAIL stall_resume_pc: got v=%b pc=%h want v=1 pc=%h", inst_valid, inst_pc, 32'(4 * j)); end
    end
  endtask

  // Redirect while a slow request is outstanding: old word dropped, restart at 0x40
  task automatic test_drain();
    bit found;
    bit stale;
    lat = 2'd3;
    do_reset();
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect = 1'b0;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin miscompares++; $display("FAIL drain_hold: got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr); end
    found = 1'b0; stale = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (inst_valid) stale = 1'b1;
      if (mem_req && mem_addr == 32'h40) found = 1'b1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL drain_new_addr: got addr=%h want 00000040 within bound", mem_addr); end
    vectors++; if (stale) begin miscompares++; $display("FAIL drain_dropped: got stale valid=1 want 0"); end
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (inst_valid) found = 1'b1;
      else @(negedge clk);
    end
    vectors++; if (!found || inst_pc !== 32'h40 || inst !== memfun(32'h40)) begin miscompares++; $display("FAIL drain_first_pc: got v=%b pc=%h want v=1 pc=00000040", inst_valid, inst_pc); end
  endtask

  // Misaligned redirect coinciding with an ack: flush, fetch 0x100, sticky error
  task automatic test_redirect_ack();
    lat = 2'd0;
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    redirect = 1'b0;
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush: got valid=%b want 0", inst_valid); end
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin miscompares++; $display("FAIL redir_addr: got req=%b addr=%h want req=1 addr=00000100", mem_req, mem_addr); end
    vectors++; if (align_err !== 1'b1) begin miscompares++; $display("FAIL redir_align_set: got %b want 1", align_err); end
    @(negedge clk);
    vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin miscompares++; $display("FAIL redir_first_pc: got v=%b pc=%h want v=1 pc=00000100", inst_valid, inst_pc); end
    repeat (8) @(negedge clk);
    vectors++; if (align_err !== 1'b1) begin miscompares++; $display("FAIL redir_align_sticky: got %b want 1", align_err); end
  endtask

  // Redirect to the top word: fetch address wraps to zero
  task automatic test_wrap();
    lat = 2'd0;
    do_reset();
    vectors++; if (align_err !== 1'b0) begin miscompares++; $display("FAIL wrap_align_cleared: got %b want 0", align_err); end
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    vectors++; if (mem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr_top: got %h want fffffffc", mem_addr); end
    @(negedge clk);
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_addr_zero: got %h want 0", mem_addr); end
    vectors++; if (inst_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_pc_top: got %h want fffffffc", inst_pc); end
    @(negedge clk);
    vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin miscompares++; $display("FAIL wrap_pc_zero: got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc); end
    vectors++; if (align_err !== 1'b0) begin miscompares++; $display("FAIL wrap_align: got %b want 0", align_err); end
  endtask

  // Reset asserted between edges with a request outstanding and data buffered
  task automatic test_async_reset();
    lat = 2'd1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    vectors++; if (mem_req !== 1'b1 || inst_valid !== 1'b1) begin miscompares++; $display("FAIL areset_pre: got req=%b v=%b want 1 1", mem_req, inst_valid); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL areset_req: got %b want 0", mem_req); end
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL areset_valid: got %b want 0", inst_valid); end
`ifdef FETCH_PERF_CNT_EN
    vectors++; if (perf_fetch_cnt !== 32'h0 || perf_bubble_cnt !== 32'h0) begin miscompares++; $display("FAIL areset_perf: got %h %h want 0 0", perf_fetch_cnt, perf_bubble_cnt); end
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    vectors++; if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin miscompares++; $display("FAIL areset_refetch: got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, RESET_PC); end
  endtask

  // Randomized traffic checked against program order: the head must always be
  // the next address in sequence since the last redirect, with matching data
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    bit          exp_align;
    bit          prev_pend;
    bit          after_redir;
    int          pops;
    lat = 2'd0;
    do_reset();
    exp_pc = RESET_PC; exp_align = 1'b0; prev_pend = 1'b0; after_redir = 1'b0; pops = 0;
    prev_addr = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (inst_valid) begin
        vectors++; if (inst_pc !== exp_pc) begin miscompares++; $display("FAIL rnd_order: cyc %0d got pc=%h want %h", cyc, inst_pc, exp_pc); end
        vectors++; if (inst !== memfun(inst_pc)) begin miscompares++; $display("FAIL rnd_data: cyc %0d got %h want %h", cyc, inst, memfun(inst_pc)); end
      end
      if (after_redir) begin
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rnd_flush: cyc %0d got valid=%b want 0", cyc, inst_valid); end
      end
      if (prev_pend) begin
        vectors++; if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin miscompares++; $display("FAIL rnd_handshake: cyc %0d got req=%b addr=%h want req=1 addr=%h", cyc, mem_req, mem_addr, prev_addr); end
      end
      vectors++; if (align_err !== exp_align) begin miscompares++; $display("FAIL rnd_align: cyc %0d got %b want %b", cyc, align_err, exp_align); end
      // choose inputs for the coming edge
      stall    = ($urandom % 10) < 3;
      redirect = ($urandom % 20) == 0;
      redirect_pc = $urandom;
      if (($urandom % 4) != 0) redirect_pc[31:12] = '0;
      noise = 1'($urandom % 2);
      if (!prev_pend) lat = 2'($urandom % 4);
      #1;
      prev_pend = mem_req && !mem_ack;
      prev_addr = mem_addr;
      if (redirect) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) exp_align = 1'b1;
        after_redir = 1'b1;
      end else begin
        after_redir = 1'b0;
        if (inst_valid && !stall) begin
          exp_pc = exp_pc + 32'd4;
          pops++;
        end
      end
      @(negedge clk);
    end
    redirect = 1'b0; stall = 1'b0; noise = 1'b0;
    vectors++; if (pops < 100) begin miscompares++; $display("FAIL rnd_progress: got %0d pops want >= 100", pops); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_drain();
    test_redirect_ack();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Fetch sequencer between the PC logic and the byte-addressed instruction memory in the MIPS pipeline.
- Issues word fetches through a req/ack handshake and buffers returned words in a small prefetch FIFO.
- Presents {instruction, pc} to the IF/ID register with a valid flag.
- Honours stall from the hazard unit and redirect from branch/jump resolution, discarding wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch entries; legal values are powers of two, 2 or more.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- stall  in  1  IF/ID hold; the head entry is not consumed.
- redirect  in  1  branch/jump taken; restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address.
- mem_req  out  1  fetch request to instruction memory.
- mem_addr  out  32  word address (byte address, [1:0]=0).
- mem_ack  in  1  memory data valid; may rise in the same cycle as mem_req.
- mem_rdata  in  32  fetched word, big-endian byte order.
- inst  out  32  head instruction.
- inst_pc  out  32  address of inst.
- inst_valid  out  1  head entry valid.
- align_err  out  1  sticky flag: a redirect_pc had [1:0]!=0.

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC; FIFO empty; state FETCH; mem_req=0; mem_addr=RESET_PC; inst=0; inst_pc=0; inst_valid=0; align_err=0.
- FSM states:
  - FETCH: mem_req=1 when FIFO count<FIFO_DEPTH; mem_addr=fetch_pc.
  - DRAIN: wrong-path request still outstanding; mem_req=1 held with the old address; on ack the data is dropped and the FSM goes to FETCH.
- Handshake:
  - Once mem_req rises, mem_req and mem_addr stay stable until the cycle mem_ack=1.
  - At most one outstanding request.
  - mem_ack while mem_req=0 is ignored.
- Normal ack in FETCH: push {fetch_pc, mem_rdata}; fetch_pc+=4 (mod 2^32, wraps at 0xFFFF_FFFC->0).
- Output and pop:
  - inst, inst_pc and inst_valid come combinationally from the FIFO head; inst_valid = !empty.
  - Pop when inst_valid && !stall && !redirect.
- Latency: first mem_req in the first clk after rst deasserts. With a same-cycle ack, inst_valid rises the next cycle. Sustained throughput is 1 instr/cycle when ack is same-cycle and stall=0.
- Full: count==FIFO_DEPTH means no new request. A pop and push in the same cycle leave count unchanged.
- Empty with stall=1: inst_valid=0; no underflow.
- Redirect (priority over push and pop):
  - Flush the FIFO; fetch_pc = {redirect_pc[31:2],2'b00}.
  - If redirect_pc[1:0]!=0, set align_err.
  - If mem_req=1 and mem_ack=0 that cycle, go to DRAIN; otherwise stay in FETCH.
  - Same-cycle ack data is discarded.
- Redirect during DRAIN: update fetch_pc only; remain in DRAIN.
- stall has no effect on fetching other than preventing the pop.
- Reset mid-request: mem_req drops asynchronously; the memory must tolerate request withdrawal on reset.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_fetch_cnt[31:0] (acked, non-discarded fetches) and perf_bubble_cnt[31:0] (cycles with inst_valid=0 and rst=0).
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - State enum {FETCH, DRAIN}.
  - Typedef fetch_entry_t {pc[31:0], inst[31:0]}.
  - Constant WORD_BYTES=4.
- One sub-module, fetch_fifo: sync FIFO parameterised by depth and width.
  - Inputs: push, pop, flush.
  - Outputs: count, head.
  - Async active-high reset.
- The FSM and PC logic stay in inst_fetch_ctrl.

Test Plan:
- Reset release, memory acks in the same cycle, stall=0 -> mem_addr 0x0,0x4,0x8 on consecutive cycles; inst_pc 0x0,0x4,0x8 with inst_valid=1 from the second cycle.
- stall=1 for 5 cycles, FIFO_DEPTH=2 -> exactly 2 entries buffered, then mem_req=0. inst_pc holds 0x0. After release, pops continue at 0x4 with no lost or duplicated pc.
- Memory acks 3 cycles after req; redirect to 0x40 on the second wait cycle -> FSM in DRAIN. The old word is dropped, the next mem_addr is 0x40, and the first inst_pc after that is 0x40.
- Redirect to 0x102 in the same cycle as an ack -> FIFO empty next cycle, fetch at 0x100, align_err=1 and staying 1 until rst.
- Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000 (wrap).
- rst asserted mid-request (async, between edges) -> mem_req=0 and inst_valid=0 immediately. After release, refetch from RESET_PC. With FETCH_PERF_CNT_EN, both counters read 0.
